vga_pixel_writer: RTL and testbench



---
 rtl/vga_pixel_writer.sv | 100 ++++++++++
 tb/tb_vga_pixel_writer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_writer.sv
// Write-port stage between the circle drawer and vga_adapter: clears the frame
// after reset or on request, then forwards drawer pixels with off-screen clipping.
module vga_pixel_writer #(
  parameter int unsigned SCREEN_WIDTH  = 160,
  parameter int unsigned SCREEN_HEIGHT = 120,
  parameter logic [2:0]  CLEAR_COLOUR  = 3'b000
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        clear_req,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  in_x,
  input  logic [8:0]  in_y,
  input  logic [2:0]  in_colour,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic        busy,
  output logic [15:0] dropped_count
);

  typedef enum logic {
    ST_CLEAR,
    ST_PASS
  } state_t;

  localparam logic [7:0] X_LAST = 8'(SCREEN_WIDTH - 1);
  localparam logic [6:0] Y_LAST = 7'(SCREEN_HEIGHT - 1);
  localparam logic [8:0] X_LIM  = 9'(SCREEN_WIDTH);
  localparam logic [8:0] Y_LIM  = 9'(SCREEN_HEIGHT);

  state_t     state;
  logic [7:0] cx;
  logic [6:0] cy;
  logic       on_screen;

  assign in_ready = (state == ST_PASS);
  assign busy     = (state == ST_CLEAR);

  // Sign bit clear rules out negatives, so the upper bound can be an unsigned compare.
  always_comb begin
    on_screen = !in_x[8] && (in_x < X_LIM) && !in_y[8] && (in_y < Y_LIM);
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_CLEAR;
      cx            <= '0;
      cy            <= '0;
      vga_x         <= '0;
      vga_y         <= '0;
      vga_colour    <= '0;
      vga_plot      <= 1'b0;
      dropped_count <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          vga_x      <= cx;
          vga_y      <= cy;
          vga_colour <= CLEAR_COLOUR;
          vga_plot   <= 1'b1;
          if (cx == X_LAST) begin
            cx <= '0;
            if (cy == Y_LAST) begin
              cy    <= '0;
              state <= ST_PASS;
            end else begin
              cy <= cy + 7'd1;
            end
          end else begin
            cx <= cx + 8'd1;
          end
        end
        ST_PASS: begin
          vga_plot <= 1'b0;
          if (in_valid) begin
            if (on_screen) begin
              vga_x      <= in_x[7:0];
              vga_y      <= in_y[6:0];
              vga_colour <= in_colour;
              vga_plot   <= 1'b1;
            end else if (dropped_count != '1) begin
              dropped_count <= dropped_count + 16'd1;
            end
          end
          // A handshake on the request edge is still served above.
          if (clear_req) begin
            state <= ST_CLEAR;
            cx    <= '0;
            cy    <= '0;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_pixel_writer.sv
// Self-checking bench for vga_pixel_writer: scoreboarded plot stream on a full-size
// instance, plus a small-screen instance for drop-counter saturation.
module tb_vga_pixel_writer;

  logic        clk = 1'b0;
  logic        rst_n, clear_req, in_valid, in_ready, vga_plot, busy;
  logic [8:0]  in_x, in_y;
  logic [2:0]  in_colour, vga_colour;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [15:0] dropped_count;

  logic        s_rst_n, s_clear_req, s_valid, s_ready, s_plot, s_busy;
  logic [8:0]  s_x, s_y;
  logic [2:0]  s_c, s_vc;
  logic [7:0]  s_vx;
  logic [6:0]  s_vy;
  logic [15:0] s_dropped;

  int unsigned compared = 0;
  int unsigned mismatched = 0;
  int unsigned exp_drop = 0;
  logic [17:0] q[$];

  always #5 clk = ~clk;

  vga_pixel_writer u_dut (
    .CLOCK_50(clk), .resetn(rst_n), .clear_req(clear_req), .in_valid(in_valid),
    .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .dropped_count(dropped_count)
  );

  vga_pixel_writer #(.SCREEN_WIDTH(8), .SCREEN_HEIGHT(4), .CLEAR_COLOUR(3'b000)) u_sat (
    .CLOCK_50(clk), .resetn(s_rst_n), .clear_req(s_clear_req), .in_valid(s_valid),
    .in_ready(s_ready), .in_x(s_x), .in_y(s_y), .in_colour(s_c),
    .vga_x(s_vx), .vga_y(s_vy), .vga_colour(s_vc), .vga_plot(s_plot),
    .busy(s_busy), .dropped_count(s_dropped)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (vga_plot === 1'b1) begin
      if (q.size() == 0) check("unexpected_plot", {vga_x, vga_y, vga_colour}, 32'hFFFF_FFFF);
      else check("pixel", {vga_x, vga_y, vga_colour}, q.pop_front());
    end
  end

  task automatic push_sweep();
    for (int unsigned yy = 0; yy < 120; yy++)
      for (int unsigned xx = 0; xx < 160; xx++)
        q.push_back({8'(xx), 7'(yy), 3'b000});
  endtask

  // Counts negedges until busy drops; in_ready must stay low throughout.
  task automatic wait_clear(input string tag);
    int unsigned n = 0, bad = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy && in_ready) bad++;
    end while (busy && n < 20000);
    check({tag, "_len"}, n, 19200);
    check({tag, "_ready_in_clear"}, bad, 0);
    check({tag, "_ready_after"}, {31'd0, in_ready}, 1);
  endtask

  task automatic send(input int x, input int y, input logic [2:0] c);
    in_x = 9'(x); in_y = 9'(y); in_colour = c; in_valid = 1'b1;
    check("send_ready", {31'd0, in_ready}, 1);
    if (x >= 0 && x < 160 && y >= 0 && y < 120) q.push_back({8'(x), 7'(y), c});
    else if (exp_drop < 65535) exp_drop++;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clear_req = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_colour = '0;
    s_rst_n = 1'b0; s_clear_req = 1'b0; s_valid = 1'b0; s_x = '0; s_y = '0; s_c = '0;
    repeat (2) @(negedge clk);
    check("rst_out", {vga_x, vga_y, vga_colour, vga_plot}, 0);
    check("rst_busy", {busy, in_ready}, 2'b10);
    check("rst_drop", dropped_count, 0);
    fork
      begin : main_seq
        // 1: power-on sweep
        push_sweep();
        rst_n = 1'b1;
        wait_clear("sweep1");
        @(negedge clk);
        check("after_sweep_noplot", {31'd0, vga_plot}, 0);
        // 2: single on-screen pixel
        send(80, 60, 3'b100);
        @(negedge clk);
        check("t2_one_cycle", {31'd0, vga_plot}, 0);
        check("t2_drop", dropped_count, 0);
        // 3: clipping boundaries
        send(-1, 60, 3'b001);
        send(160, 0, 3'b001);
        send(0, 120, 3'b001);
        send(-256, 255, 3'b001);
        check("t3_drop4", dropped_count, 4);
        send(159, 119, 3'b111);
        check("t3_drop_model", dropped_count, exp_drop);
        @(negedge clk);
        // 4: clear_req with simultaneous handshake, then held pixel
        in_x = 9'd10; in_y = 9'd10; in_colour = 3'b010; in_valid = 1'b1; clear_req = 1'b1;
        q.push_back({8'd10, 7'd10, 3'b010});
        push_sweep();
        q.push_back({8'd20, 7'd30, 3'b101});
        @(negedge clk);
        clear_req = 1'b0;
        in_x = 9'd20; in_y = 9'd30; in_colour = 3'b101;
        check("t4_busy", {busy, in_ready}, 2'b10);
        wait_clear("sweep2");
        @(negedge clk);
        in_valid = 1'b0;
        check("t4_drop_kept", dropped_count, 4);
        @(negedge clk);
        check("t4_queue_empty", q.size(), 0);
        // 5: asynchronous reset mid-sweep
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        push_sweep();
        repeat (5000) @(negedge clk);
        check("t5_mid_plot", {31'd0, vga_plot}, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_out", {vga_x, vga_y, vga_colour, vga_plot}, 0);
        check("t5_rst_state", {busy, in_ready}, 2'b10);
        check("t5_rst_drop", dropped_count, 0);
        q.delete();
        exp_drop = 0;
        @(negedge clk);
        push_sweep();
        rst_n = 1'b1;
        wait_clear("sweep3");
        @(negedge clk);
        check("t5_queue_empty", q.size(), 0);
        check("t5_drop", dropped_count, exp_drop);
      end
      begin : sat_seq
        int unsigned n = 0, plots = 0;
        s_rst_n = 1'b1;
        do begin
          @(negedge clk);
          n++;
        end while (s_busy && n < 100);
        check("sat_sweep_len", n, 32);
        check("sat_ready", {31'd0, s_ready}, 1);
        s_x = 9'h1FB; s_y = 9'd0; s_c = 3'b111; s_valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
          @(negedge clk);
          if (s_plot) plots++;
        end
        check("sat_at_max", s_dropped, 16'hFFFF);
        repeat (2) @(negedge clk);
        check("sat_hold", s_dropped, 16'hFFFF);
        check("sat_no_plots", plots, 0);
        s_x = 9'd3; s_y = 9'd2; s_c = 3'b110;
        @(negedge clk);
        s_valid = 1'b0;
        check("sat_onscreen", {s_vx, s_vy, s_vc, s_plot}, {8'd3, 7'd2, 3'b110, 1'b1});
        check("sat_hold2", s_dropped, 16'hFFFF);
      end
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
